// File: rtl/jb_tdd_seq_pkg.sv
// -----------------------------------------------------------------------------
// jb_tdd_seq_pkg
//
// Purpose:
//     Shared definitions for the TDD antenna-switch sequencer slice: the
//     sequencer state encoding, default parameter values, the bit positions
//     inside the pa_lna_en register field, and small state-classification
//     helpers used by the top level.
//
// Contents:
//     NUM_LANES_DEF   default number of PA/LNA lanes
//     DLY_W_DEF       default width of the guard delay / guard counter
//     PA_LNA_PA_BIT   pa_lna_en bit holding the global PA enable
//     PA_LNA_LNA_BIT  pa_lna_en bit holding the global LNA enable
//     seq_state_e     sequencer state encoding
//     is_timed_state  1 for the states that run the guard timer
//     is_busy_state   1 for every state other than the two ON states
// -----------------------------------------------------------------------------
package jb_tdd_seq_pkg;

    localparam int NUM_LANES_DEF  = 8;
    localparam int DLY_W_DEF      = 16;

    localparam int PA_LNA_PA_BIT  = 0;
    localparam int PA_LNA_LNA_BIT = 1;

    typedef enum logic [2:0] {
        RX_ON    = 3'd0,
        RX_GUARD = 3'd1,
        TX_SW    = 3'd2,
        TX_ON    = 3'd3,
        TX_GUARD = 3'd4,
        RX_SW    = 3'd5,
        SAFE     = 3'd6
    } seq_state_e;

    // The four break-before-make wait states; each one lasts exactly
    // max(ant_switch_delay, 1) cycles and is paced by the guard timer.
    function automatic logic is_timed_state(input seq_state_e s);
        return (s == RX_GUARD) || (s == TX_SW) ||
               (s == TX_GUARD) || (s == RX_SW);
    endfunction

    // SAFE is not timed but still counts as busy: nothing is radiating or
    // receiving, and software should treat the front end as unavailable.
    function automatic logic is_busy_state(input seq_state_e s);
        return (s != RX_ON) && (s != TX_ON);
    endfunction

endpackage

// File: rtl/jb_guard_timer.sv
// -----------------------------------------------------------------------------
// jb_guard_timer
//
// Purpose:
//     Down-counter that paces the break-before-make guard states. On load it
//     captures max(load_val, 1) so a programmed delay of zero still yields a
//     one-cycle guard. It then counts down once per cycle; done is high for
//     the single cycle in which the count equals 1, which is the last cycle
//     of the guard state that owns the timer.
//
// Ports:
//     clk       in   system clock
//     rst_n     in   synchronous active-low reset; reset loads the counter
//     load      in   capture a fresh guard time this cycle
//     load_val  in   guard time in clk cycles (0 treated as 1)
//     done      out  count has reached 1 (final cycle of the guard)
// -----------------------------------------------------------------------------
module jb_guard_timer #(
    parameter int DLY_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DLY_W-1:0] load_val,
    output logic             done
);

    logic [DLY_W-1:0] count_q;
    logic [DLY_W-1:0] count_d;
    logic [DLY_W-1:0] load_clamped;

    // Zero-to-one clamp so that every guard state lasts at least one cycle
    // and the sequencer can never skip a break-before-make step.
    always_comb begin
        load_clamped = load_val;
        if (load_val == '0) begin
            load_clamped = DLY_W'(1);
        end
    end

    // Load has priority over counting. Once the count has reached zero it
    // parks there until the next load, so done cannot fire a second time.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_clamped;
        end else if (count_q != '0) begin
            count_d = count_q - DLY_W'(1);
        end
    end

    // Reset loads the counter because the sequencer leaves reset directly
    // in a guard state that needs a full guard time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= load_clamped;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        done = (count_q == DLY_W'(1));
    end

endmodule

// File: rtl/jb_tdd_ant_sw_seq.sv
// -----------------------------------------------------------------------------
// jb_tdd_ant_sw_seq
//
// Purpose:
//     TDD RF front-end sequencer. Follows the live TDD slot strobe and walks
//     the antenna T/R switch, the PA enables and the LNA enables through a
//     break-before-make sequence so that the PA is never on while the switch
//     is moving or while any LNA is live. A register-driven override forces
//     a safe state, and per-lane PA power-good loss latches a sticky fault
//     that keeps that lane's PA masked until software clears it.
//
// Ports:
//     clk                 in   system clock
//     rst_n               in   synchronous active-low reset
//     tdd_tx              in   TDD slot: 1 = TX slot, 0 = RX slot
//     tdd_ctrl_pa         in   per-lane TDD participation mask
//     pa_lna_en           in   bit0 global PA enable, bit1 global LNA enable
//     ant_switch_delay    in   guard time in clk cycles (0 behaves as 1)
//     rf_switch_override  in   force the safe state
//     tx_ant_cal_en       in   switch position while overridden
//     pa_v_pgood          in   PA supply power-good per lane
//     fault_clr           in   single-cycle clear of pa_fault
//     pa_en               out  PA enable per lane
//     lna_en              out  LNA enable per lane
//     ant_sw_tx           out  antenna switch, 1 = TX path
//     seq_busy            out  sequencer is in a guard state or SAFE
//     pa_fault            out  sticky per-lane power-good fault
// -----------------------------------------------------------------------------
module jb_tdd_ant_sw_seq
    import jb_tdd_seq_pkg::*;
#(
    parameter int NUM_LANES = NUM_LANES_DEF,
    parameter int DLY_W     = DLY_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tdd_tx,
    input  logic [NUM_LANES-1:0] tdd_ctrl_pa,
    input  logic [1:0]           pa_lna_en,
    input  logic [DLY_W-1:0]     ant_switch_delay,
    input  logic                 rf_switch_override,
    input  logic                 tx_ant_cal_en,
    input  logic [NUM_LANES-1:0] pa_v_pgood,
    input  logic                 fault_clr,
    output logic [NUM_LANES-1:0] pa_en,
    output logic [NUM_LANES-1:0] lna_en,
    output logic                 ant_sw_tx,
    output logic                 seq_busy,
    output logic [NUM_LANES-1:0] pa_fault
);

    seq_state_e           state_q;
    seq_state_e           state_d;

    logic [NUM_LANES-1:0] pa_en_q;
    logic [NUM_LANES-1:0] pa_en_d;
    logic [NUM_LANES-1:0] lna_en_q;
    logic [NUM_LANES-1:0] lna_en_d;
    logic                 ant_sw_tx_q;
    logic                 ant_sw_tx_d;
    logic                 seq_busy_q;
    logic                 seq_busy_d;
    logic [NUM_LANES-1:0] pa_fault_q;
    logic [NUM_LANES-1:0] pa_fault_d;

    logic [NUM_LANES-1:0] fault_set;
    logic [NUM_LANES-1:0] pa_gate;
    logic [NUM_LANES-1:0] lna_gate;
    logic                 timer_load;
    logic                 timer_done;

    // The guard timer is reloaded exactly when the FSM moves into a timed
    // state, so ant_switch_delay is only sampled at that moment and a
    // mid-guard change waits for the next guard.
    always_comb begin
        timer_load = (state_d != state_q) && is_timed_state(state_d);
    end

    jb_guard_timer #(
        .DLY_W (DLY_W)
    ) u_guard_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (ant_switch_delay),
        .done     (timer_done)
    );

    // Next-state logic. Override beats everything, from any state. Guard
    // states only ever advance forward when their timer finishes, so a
    // tdd_tx toggle during a guard never aborts the sequence; the ON states
    // are the only places where tdd_tx is looked at. Leaving SAFE always
    // goes through a fresh RX_SW guard so TX_ON can never be entered
    // straight out of an override.
    always_comb begin
        state_d = state_q;
        if (rf_switch_override) begin
            state_d = SAFE;
        end else begin
            case (state_q)
                RX_ON: begin
                    if (tdd_tx) begin
                        state_d = RX_GUARD;
                    end
                end
                RX_GUARD: begin
                    if (timer_done) begin
                        state_d = TX_SW;
                    end
                end
                TX_SW: begin
                    if (timer_done) begin
                        state_d = TX_ON;
                    end
                end
                TX_ON: begin
                    if (!tdd_tx) begin
                        state_d = TX_GUARD;
                    end
                end
                TX_GUARD: begin
                    if (timer_done) begin
                        state_d = RX_SW;
                    end
                end
                RX_SW: begin
                    if (timer_done) begin
                        state_d = RX_ON;
                    end
                end
                SAFE: begin
                    state_d = RX_SW;
                end
                default: begin
                    state_d = SAFE;
                end
            endcase
        end
    end

    // Sticky power-good fault. A lane faults only if its PA was actually
    // enabled when pgood dropped (pa_en_q is non-zero only in TX_ON). A new
    // fault in the same cycle as fault_clr survives the clear.
    always_comb begin
        fault_set  = pa_en_q & ~pa_v_pgood;
        pa_fault_d = fault_set | (fault_clr ? '0 : pa_fault_q);
    end

    // Lane masks for the ON states. The PA mask uses the next fault value so
    // a lane drops out in the same cycle its fault is latched and comes back
    // in the same cycle its fault is cleared (provided pgood is good again).
    always_comb begin
        pa_gate  = tdd_ctrl_pa & pa_v_pgood & ~pa_fault_d &
                   {NUM_LANES{pa_lna_en[PA_LNA_PA_BIT]}};
        lna_gate = tdd_ctrl_pa & {NUM_LANES{pa_lna_en[PA_LNA_LNA_BIT]}};
    end

    // Output decode from the next state, so that the registered outputs
    // change on the same edge as the state register. Each state drives at
    // most one of the PA / LNA groups, and the switch is only ever moved in
    // states where both groups are off.
    always_comb begin
        pa_en_d     = '0;
        lna_en_d    = '0;
        ant_sw_tx_d = 1'b0;
        case (state_d)
            RX_ON: begin
                lna_en_d = lna_gate;
            end
            RX_GUARD, RX_SW: begin
                ant_sw_tx_d = 1'b0;
            end
            TX_SW, TX_GUARD: begin
                ant_sw_tx_d = 1'b1;
            end
            TX_ON: begin
                ant_sw_tx_d = 1'b1;
                pa_en_d     = pa_gate;
            end
            SAFE: begin
                ant_sw_tx_d = tx_ant_cal_en;
            end
            default: begin
                ant_sw_tx_d = 1'b0;
            end
        endcase
        seq_busy_d = is_busy_state(state_d);
    end

    // State and output registers. Reset parks the sequencer in RX_SW with
    // the guard timer loaded, so the LNAs come up only after one full guard
    // time following reset release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RX_SW;
            pa_en_q     <= '0;
            lna_en_q    <= '0;
            ant_sw_tx_q <= 1'b0;
            seq_busy_q  <= 1'b1;
            pa_fault_q  <= '0;
        end else begin
            state_q     <= state_d;
            pa_en_q     <= pa_en_d;
            lna_en_q    <= lna_en_d;
            ant_sw_tx_q <= ant_sw_tx_d;
            seq_busy_q  <= seq_busy_d;
            pa_fault_q  <= pa_fault_d;
        end
    end

    always_comb begin
        pa_en     = pa_en_q;
        lna_en    = lna_en_q;
        ant_sw_tx = ant_sw_tx_q;
        seq_busy  = seq_busy_q;
        pa_fault  = pa_fault_q;
    end

    // Front-end safety invariants: PA and LNA groups are mutually exclusive,
    // the PA is off in any cycle that follows a switch movement, and the PA
    // is never enabled while the sequencer reports busy.
    a_pa_lna_exclusive : assert property (
        @(posedge clk) disable iff (!rst_n)
        (pa_en_q == '0) || (lna_en_q == '0)
    );

    a_no_switch_under_pa : assert property (
        @(posedge clk) disable iff (!rst_n)
        (ant_sw_tx_q != $past(ant_sw_tx_q)) |-> (pa_en_q == '0)
    );

    a_no_pa_while_busy : assert property (
        @(posedge clk) disable iff (!rst_n)
        seq_busy_q |-> (pa_en_q == '0)
    );

endmodule
